// File: rtl/qick_defines_pkg.sv
// Shared QICK core definitions: dispatcher FSM states, the queued wave/time entry
// and wrap-safe time comparison helpers.
package qick_defines_pkg;

  localparam int QICK_WAVE_W = 168;
  localparam int QICK_TIME_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } dispatch_state_e;

  typedef struct packed {
    logic [QICK_TIME_W-1:0] time_q;
    logic [QICK_WAVE_W-1:0] wave;
  } wave_entry_t;

  // The time counter wraps, so "due" means the signed distance from the schedule is non-negative.
  function automatic logic time_due(input logic [QICK_TIME_W-1:0] t_now,
                                    input logic [QICK_TIME_W-1:0] t_sched);
    logic [QICK_TIME_W-1:0] diff;
    diff = t_now - t_sched;
    return !diff[QICK_TIME_W-1];
  endfunction

  function automatic logic time_late(input logic [QICK_TIME_W-1:0] t_now,
                                     input logic [QICK_TIME_W-1:0] t_sched);
    logic [QICK_TIME_W-1:0] diff;
    diff = t_now - t_sched;
    return !diff[QICK_TIME_W-1] && (diff != '0);
  endfunction

endpackage

// File: rtl/qcore_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered array and
// extra-MSB pointers; a write while full is accepted only alongside a read.
module qcore_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_cnt,
  output logic             o_wr_drop
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_wr_commit;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_ok     = i_rd_en && !w_empty;
  assign w_wr_ok     = i_wr_en && (!w_full || w_rd_ok);
  assign w_wr_commit = w_wr_ok && !i_rst && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // When full with a simultaneous read, the write lands in the slot being vacated.
  always_ff @(posedge i_clk) begin
    if (w_wr_commit) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_cnt     = r_wr_ptr - r_rd_ptr;
  assign o_wr_drop = i_wr_en && w_full && !w_rd_ok;

endmodule

// File: rtl/qcore_wave_dispatch.sv
// Timed wave dispatcher: queues {time, wave} pushes and presents each wave to the
// signal-generator port once the absolute time counter reaches its scheduled time.
module qcore_wave_dispatch
  import qick_defines_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int WAVE_W  = 168
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [WAVE_W-1:0] wreg_i,
  input  logic [31:0]       time_i,
  input  logic [31:0]       t_now_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [WAVE_W-1:0] m_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [FIFO_AW:0]  cnt_o,
  output logic              late_o,
  output logic              ovf_o
);

  localparam int ENTRY_W = WAVE_W + 32;

  dispatch_state_e     r_state;
  dispatch_state_e     w_state_nxt;
  logic [WAVE_W-1:0]   r_data;
  logic                r_late;
  logic                r_ovf;
  logic [ENTRY_W-1:0]  w_head;
  logic [31:0]         w_head_time;
  logic [WAVE_W-1:0]   w_head_wave;
  logic                w_empty;
  logic                w_full;
  logic                w_due;
  logic                w_pop;
  logic                w_drop;

  qcore_sync_fifo #(
    .WIDTH (ENTRY_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_flush   (flush_i),
    .i_wr_en   (push_i),
    .i_wr_data ({time_i, wreg_i}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_cnt     (cnt_o),
    .o_wr_drop (w_drop)
  );

  assign w_head_time = w_head[WAVE_W +: 32];
  assign w_head_wave = w_head[WAVE_W-1:0];
  assign w_due       = time_due(t_now_i, w_head_time);
  assign w_pop       = (r_state == ST_WAIT) && !w_empty && w_due;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (!w_empty) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_empty)    w_state_nxt = ST_IDLE;
        else if (w_due) w_state_nxt = ST_PRESENT;
      end
      ST_PRESENT: if (m_ready_i) w_state_nxt = w_empty ? ST_IDLE : ST_WAIT;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // The presented word is captured at issue so it cannot follow later register-bank writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_late  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_late  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_late  <= w_pop && time_late(t_now_i, w_head_time);
      if (w_pop)  r_data <= w_head_wave;
      if (w_drop) r_ovf  <= 1'b1;
    end
  end

  assign m_valid_o = (r_state == ST_PRESENT);
  assign m_data_o  = r_data;
  assign full_o    = w_full;
  assign empty_o   = w_empty;
  assign late_o    = r_late;
  assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_qcore_wave_dispatch.sv
// Bench for qcore_wave_dispatch: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the dispatcher behaviour.
module tb_qcore_wave_dispatch;

  localparam int FIFO_AW = 3;
  localparam int WAVE_W  = 168;
  localparam int DEPTH   = 1 << FIFO_AW;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              push_i;
  logic [WAVE_W-1:0] wreg_i;
  logic [31:0]       time_i;
  logic [31:0]       t_now_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [WAVE_W-1:0] m_data_o;
  logic              full_o;
  logic              empty_o;
  logic [FIFO_AW:0]  cnt_o;
  logic              late_o;
  logic              ovf_o;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  logic [31:0] tNow = 32'd0;

  typedef struct {
    logic [31:0]       tm;
    logic [WAVE_W-1:0] wave;
  } entry_t;

  entry_t            modelQ[$];
  bit                modelArmed = 1'b0;
  bit                modelPres  = 1'b0;
  bit                modelLate  = 1'b0;
  bit                modelOvf   = 1'b0;
  logic [WAVE_W-1:0] modelData  = '0;

  always #5 clk_i = ~clk_i;

  qcore_wave_dispatch #(
    .FIFO_AW (FIFO_AW),
    .WAVE_W  (WAVE_W)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .push_i    (push_i),
    .wreg_i    (wreg_i),
    .time_i    (time_i),
    .t_now_i   (t_now_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .cnt_o     (cnt_o),
    .late_o    (late_o),
    .ovf_o     (ovf_o)
  );

  function automatic logic [WAVE_W-1:0] randWave();
    logic [191:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return v[WAVE_W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [199:0] observed,
                             input logic [199:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // A queued head is only examined once the dispatcher has noticed the queue is non-empty
  // (one cycle after it was seen non-empty while idle, or right after an accepted word).
  task automatic modelStep(input bit rst, input bit flush, input bit push,
                           input logic [WAVE_W-1:0] wave, input logic [31:0] tm,
                           input logic [31:0] now, input bit ready);
    bit          pop;
    int          sizeBefore;
    logic [31:0] diff;
    entry_t      e;
    sizeBefore = modelQ.size();
    pop = 1'b0;
    if (rst) begin
      modelQ.delete();
      modelArmed = 1'b0;
      modelPres  = 1'b0;
      modelLate  = 1'b0;
      modelOvf   = 1'b0;
      modelData  = '0;
    end else if (flush) begin
      modelQ.delete();
      modelArmed = 1'b0;
      modelPres  = 1'b0;
      modelLate  = 1'b0;
      modelOvf   = 1'b0;
    end else begin
      modelLate = 1'b0;
      if (modelPres) begin
        if (ready) begin
          modelPres  = 1'b0;
          modelArmed = (sizeBefore != 0);
        end
      end else if (modelArmed) begin
        if (sizeBefore == 0) begin
          modelArmed = 1'b0;
        end else begin
          diff = now - modelQ[0].tm;
          if ($signed(diff) >= 0) begin
            pop        = 1'b1;
            modelData  = modelQ[0].wave;
            modelLate  = ($signed(diff) > 0);
            modelPres  = 1'b1;
            modelArmed = 1'b0;
            void'(modelQ.pop_front());
          end
        end
      end else if (sizeBefore != 0) begin
        modelArmed = 1'b1;
      end
      if (push) begin
        if (sizeBefore < DEPTH || pop) begin
          e.tm   = tm;
          e.wave = wave;
          modelQ.push_back(e);
        end else begin
          modelOvf = 1'b1;
        end
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("m_valid", m_valid_o, modelPres);
    checkOutput("m_data", m_data_o, modelData);
    checkOutput("cnt", cnt_o, modelQ.size());
    checkOutput("empty", empty_o, (modelQ.size() == 0));
    checkOutput("full", full_o, (modelQ.size() == DEPTH));
    checkOutput("late", late_o, modelLate);
    checkOutput("ovf", ovf_o, modelOvf);
  endtask

  task automatic applyStimulus(input bit rst, input bit flush, input bit push,
                               input logic [WAVE_W-1:0] wave, input logic [31:0] tm,
                               input bit ready);
    rst_i     = rst;
    flush_i   = flush;
    push_i    = push;
    wreg_i    = wave;
    time_i    = tm;
    m_ready_i = ready;
    t_now_i   = tNow;
    @(posedge clk_i);
    modelStep(rst, flush, push, wave, tm, tNow, ready);
    #1;
    compareAll();
    tNow = tNow + 32'd1;
  endtask

  task automatic idleCycle(input bit ready);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 32'd0, ready);
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_valid"}, m_valid_o, 1'b0);
    checkOutput({pfx, "_data"}, m_data_o, '0);
    checkOutput({pfx, "_cnt"}, cnt_o, '0);
    checkOutput({pfx, "_empty"}, empty_o, 1'b1);
    checkOutput({pfx, "_full"}, full_o, 1'b0);
    checkOutput({pfx, "_late"}, late_o, 1'b0);
    checkOutput({pfx, "_ovf"}, ovf_o, 1'b0);
  endtask

  initial begin
    logic [WAVE_W-1:0] w;
    logic [WAVE_W-1:0] seenData;
    logic [WAVE_W-1:0] waves [9];
    logic [WAVE_W-1:0] got [8];
    logic [31:0]       issueAt;
    logic [31:0]       nowUsed;
    logic [31:0]       tm;
    bit                found;
    bit                sawLate;
    int                k;
    int                r;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    checkResetState("reset");

    // Exactly on time: issue when t_now reaches the scheduled time, no late pulse
    tNow = 32'd90;
    w = randWave();
    applyStimulus(1'b0, 1'b0, 1'b1, w, 32'd100, 1'b1);
    found = 1'b0; issueAt = '0; sawLate = 1'b1; seenData = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      nowUsed = tNow;
      idleCycle(1'b1);
      if (m_valid_o) begin
        found = 1'b1; issueAt = nowUsed; sawLate = late_o; seenData = m_data_o;
      end
    end
    checkOutput("ontime_found", found, 1'b1);
    checkOutput("ontime_issue_t", issueAt, 32'd100);
    checkOutput("ontime_late", sawLate, 1'b0);
    checkOutput("ontime_data", seenData, w);
    idleCycle(1'b1);
    idleCycle(1'b1);

    // Already due: valid after the third edge counting the push edge, with one late pulse
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 32'd0, 1'b0);
    tNow = 32'd60;
    w = randWave();
    applyStimulus(1'b0, 1'b0, 1'b1, w, 32'd50, 1'b0);
    checkOutput("due_e1_valid", m_valid_o, 1'b0);
    idleCycle(1'b0);
    checkOutput("due_e2_valid", m_valid_o, 1'b0);
    idleCycle(1'b0);
    checkOutput("due_e3_valid", m_valid_o, 1'b1);
    checkOutput("due_e3_late", late_o, 1'b1);
    checkOutput("due_e3_data", m_data_o, w);

    // Back-pressure holds the word; then flush (with a concurrent push) clears everything
    for (int i = 0; i < 5; i++) begin
      idleCycle(1'b0);
      checkOutput("hold_valid", m_valid_o, 1'b1);
      checkOutput("hold_data", m_data_o, w);
      checkOutput("hold_late", late_o, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, randWave(), tNow, 1'b0);
    checkOutput("flush_valid", m_valid_o, 1'b0);
    checkOutput("flush_cnt", cnt_o, '0);
    checkOutput("flush_empty", empty_o, 1'b1);

    // Overflow: nine future pushes, then drain in push order
    tNow = 32'd1000;
    for (int i = 0; i < 9; i++) begin
      waves[i] = randWave();
      applyStimulus(1'b0, 1'b0, 1'b1, waves[i], 32'd5000, 1'b0);
    end
    checkOutput("ovf_cnt", cnt_o, 4'd8);
    checkOutput("ovf_full", full_o, 1'b1);
    checkOutput("ovf_flag", ovf_o, 1'b1);
    tNow = 32'd6000;
    k = 0;
    for (int i = 0; i < 60 && k < 8; i++) begin
      idleCycle(1'b1);
      if (m_valid_o) begin
        got[k] = m_data_o;
        k = k + 1;
      end
    end
    checkOutput("drain_count", k, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < k) checkOutput("drain_order", got[i], waves[i]);
    end

    // Wrap-safe comparison across the 32-bit rollover
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 32'd0, 1'b1);
    tNow = 32'hFFFF_FFF0;
    applyStimulus(1'b0, 1'b0, 1'b1, randWave(), 32'h0000_0010, 1'b1);
    found = 1'b0; issueAt = '0; sawLate = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      nowUsed = tNow;
      idleCycle(1'b1);
      if (m_valid_o) begin
        found = 1'b1; issueAt = nowUsed; sawLate = late_o;
      end
    end
    checkOutput("wrap_found", found, 1'b1);
    checkOutput("wrap_issue_t", issueAt, 32'h0000_0010);
    checkOutput("wrap_late", sawLate, 1'b0);
    idleCycle(1'b1);

    // Reset while presenting with three entries still queued
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 32'd0, 1'b0);
    tNow = 32'd2000;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, randWave(), 32'd2000, 1'b0);
    checkOutput("pre_rst_valid", m_valid_o, 1'b1);
    checkOutput("pre_rst_cnt", cnt_o, 4'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    checkResetState("midrst");

    // Randomized traffic against the reference model
    tNow = $urandom;
    for (int i = 0; i < 800; i++) begin
      r  = int'($urandom_range(0, 199));
      tm = tNow + 32'($urandom_range(0, 25)) - 32'd5;
      applyStimulus((r == 0), (r >= 1 && r <= 3), ($urandom_range(0, 99) < 45),
                    randWave(), tm, ($urandom_range(0, 99) < 50));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
